// File: rtl/irq_arb_pkg.sv
// Shared types and helpers for the interrupt arbiter.
package irq_arb_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    WAIT_ACK,
    GAP
  } state_e;

  typedef enum logic {
    SRC_KEY,
    SRC_ETH
  } src_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/irq_fifo.sv
// Synchronous FIFO. A push into a full FIFO is accepted if the same FIFO
// is popped in that cycle; otherwise the push is ignored.
module irq_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CAP);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; when full with a simultaneous pop, the slot being read is reused.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/irq_arbiter.sv
// Buffers keyboard and board-link events and presents them to the processor
// as single-cycle interrupt pulses, one in flight at a time, round-robin.
module irq_arbiter
  import irq_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ETH_W       = 24,
  parameter int unsigned KEY_DEPTH   = 4,
  parameter int unsigned ETH_DEPTH   = 4,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              key_evt,
  input  logic [DATA_W-1:0] key_data,
  input  logic              eth_evt,
  input  logic [ETH_W-1:0]  eth_data,
  output logic              irq_key,
  output logic              irq_eth,
  output logic [DATA_W-1:0] irq_data,
  input  logic              irq_ack,
  output logic              busy,
  output logic [CNT_W-1:0]  key_drops,
  output logic [CNT_W-1:0]  eth_drops,
  output logic [CNT_W-1:0]  timeouts
);

  localparam int unsigned KCW   = $clog2(KEY_DEPTH) + 1;
  localparam int unsigned ECW   = $clog2(ETH_DEPTH) + 1;
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT);
  localparam logic [KCW-1:0]   KEY_CAP  = KCW'(KEY_DEPTH);
  localparam logic [ECW-1:0]   ETH_CAP  = ECW'(ETH_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT - 1);

  state_e             state_q, state_d;
  src_e               src_q, src_d;
  logic [DATA_W-1:0]  irq_data_q, irq_data_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   key_drops_q, key_drops_d;
  logic [CNT_W-1:0]   eth_drops_q, eth_drops_d;
  logic [CNT_W-1:0]   timeouts_q, timeouts_d;

  logic               key_pop, eth_pop;
  logic               key_full, key_empty, eth_full, eth_empty;
  logic [KCW-1:0]     key_count;
  logic [ECW-1:0]     eth_count;
  logic [DATA_W-1:0]  key_head;
  logic [ETH_W-1:0]   eth_head;

  irq_fifo #(.WIDTH(DATA_W), .DEPTH(KEY_DEPTH)) u_key_fifo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .push    (key_evt),
    .din     (key_data),
    .pop     (key_pop),
    .dout    (key_head),
    .full    (key_full),
    .empty   (key_empty),
    .count   (key_count)
  );

  irq_fifo #(.WIDTH(ETH_W), .DEPTH(ETH_DEPTH)) u_eth_fifo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .push    (eth_evt),
    .din     (eth_data),
    .pop     (eth_pop),
    .dout    (eth_head),
    .full    (eth_full),
    .empty   (eth_empty),
    .count   (eth_count)
  );

  assert property (@(posedge sys_clk) disable iff (!rst_n) key_count <= KEY_CAP);
  assert property (@(posedge sys_clk) disable iff (!rst_n) eth_count <= ETH_CAP);

  assign irq_key   = (state_q == PRESENT) && (src_q == SRC_KEY);
  assign irq_eth   = (state_q == PRESENT) && (src_q == SRC_ETH);
  assign irq_data  = irq_data_q;
  assign busy      = (state_q != IDLE);
  assign key_drops = key_drops_q;
  assign eth_drops = eth_drops_q;
  assign timeouts  = timeouts_q;

  // Arbitration and interrupt handshake. src_q doubles as the round-robin
  // pointer: it only changes on a pop, and the source not recorded there wins.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    irq_data_d = irq_data_q;
    tmo_d      = tmo_q;
    timeouts_d = timeouts_q;
    key_pop    = 1'b0;
    eth_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!eth_empty && (key_empty || src_q == SRC_KEY)) begin
          eth_pop    = 1'b1;
          src_d      = SRC_ETH;
          irq_data_d = DATA_W'(eth_head);
          state_d    = PRESENT;
        end else if (!key_empty) begin
          key_pop    = 1'b1;
          src_d      = SRC_KEY;
          irq_data_d = key_head;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        tmo_d   = TMO_LOAD;
        state_d = irq_ack ? GAP : WAIT_ACK;
      end
      WAIT_ACK: begin
        if (irq_ack) begin
          state_d = GAP;
        end else if (tmo_q == '0) begin
          timeouts_d = sat_inc(timeouts_q);
          state_d    = GAP;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Drop counters for events arriving at a full FIFO that is not being drained.
  always_comb begin
    key_drops_d = key_drops_q;
    eth_drops_d = eth_drops_q;
    if (key_evt && key_full && !key_pop) key_drops_d = sat_inc(key_drops_q);
    if (eth_evt && eth_full && !eth_pop) eth_drops_d = sat_inc(eth_drops_q);
  end

  // State register; reset leaves the pointer on KEY so ETH is served first.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= SRC_KEY;
      irq_data_q  <= '0;
      tmo_q       <= '0;
      key_drops_q <= '0;
      eth_drops_q <= '0;
      timeouts_q  <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      irq_data_q  <= irq_data_d;
      tmo_q       <= tmo_d;
      key_drops_q <= key_drops_d;
      eth_drops_q <= eth_drops_d;
      timeouts_q  <= timeouts_d;
    end
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Merges the two asynchronous-to-software event sources into the processor's interrupt path, one interrupt in flight at a time.
  - Keyboard events arrive as a done pulse plus a 32-bit code.
  - Board-link frames arrive as an rx pulse plus 24-bit data.
- Each source is buffered in its own FIFO and the two are served round-robin.
- Each interrupt is held until software acknowledges it or a timeout expires.
- Sits between keyboard/spart_top and proc, replacing the ad-hoc interrupt_source_data mux.

Parameters:
- DATA_W, 32, width of irq_data and of the key code
- ETH_W, 24, width of the board-link frame
- KEY_DEPTH, 4, key FIFO entries (power of 2, ≥2)
- ETH_DEPTH, 4, board FIFO entries (power of 2, ≥2)
- ACK_TIMEOUT, 1024, cycles to wait for irq_ack before abandoning an interrupt (≥2)

Ports:
- sys_clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- key_evt  in  1  one-cycle keyboard event pulse
- key_data  in  DATA_W  key code, valid with key_evt
- eth_evt  in  1  one-cycle board-frame pulse
- eth_data  in  ETH_W  frame, valid with eth_evt
- irq_key  out  1  one-cycle pulse to proc interrupt_key
- irq_eth  out  1  one-cycle pulse to proc interrupt_eth
- irq_data  out  DATA_W  payload of the current interrupt
- irq_ack  in  1  software done with the current interrupt (level or pulse)
- busy  out  1  interrupt in flight (state ≠ IDLE)
- key_drops  out  8  saturating count of key events lost to a full FIFO
- eth_drops  out  8  saturating count of frames lost to a full FIFO
- timeouts  out  8  saturating count of interrupts abandoned without ack

Behaviour:
- Reset: all outputs 0, both FIFOs empty, state IDLE, round-robin pointer favours ETH, counters cleared.
- Push rules:
  - A push is accepted when count < DEPTH, or when the same FIFO is popped in that cycle.
  - Otherwise the event is dropped and the matching drop counter increments; it saturates at 255.
- ETH payload is zero-extended to DATA_W.
- FSM states: IDLE → PRESENT → WAIT_ACK → GAP → IDLE.
  - IDLE, one FIFO non-empty: pop that FIFO, latch its head into irq_data, record the source, go to PRESENT.
  - IDLE, both non-empty: pop the source not served last. After reset, ETH wins.
  - PRESENT, exactly one cycle:
    - Pulse irq_key or irq_eth (never both).
    - Load the timeout counter with ACK_TIMEOUT-1.
    - If irq_ack is high, go to GAP; else go to WAIT_ACK.
  - WAIT_ACK:
    - irq_ack high: go to GAP.
    - Counter reaches 0 without ack: increment timeouts (saturating) and go to GAP.
    - Otherwise decrement the counter.
  - GAP, one cycle: go to IDLE. This guarantees at least 2 idle cycles between interrupt pulses.
- irq_data is stable from PRESENT until the next PRESENT. It does not change while waiting for ack.
- irq_ack is ignored in IDLE and GAP; there is no carry-over.
- Latency: an event in cycle t with an empty FIFO and the FSM in IDLE gives the irq pulse in cycle t+2.
  - t+1 is the pop/latch cycle.
- Simultaneous key_evt and eth_evt: both are pushed independently. Arbitration order follows the round-robin rule.
- FIFO ordering is strictly FIFO within a source.
- The round-robin pointer updates only on a pop.
- Reset mid-interrupt: pending FIFO contents are discarded, no pulse is issued, state returns to IDLE.

Decomposition:
- Package irq_arb_pkg holds:
  - state enum (IDLE, PRESENT, WAIT_ACK, GAP)
  - source enum (SRC_KEY, SRC_ETH)
  - the saturating-counter width constant CNT_W = 8
- Sub-module irq_fifo: synchronous FIFO parameterised on width and depth, with push/pop/full/empty/count. Instantiated twice.

Test Plan:
- Single key_evt with key_data=104, ack 5 cycles after the pulse:
  - irq_key pulses at t+2 with irq_data=104.
  - busy falls 2 cycles after ack.
  - timeouts stays 0.
- key_evt and eth_evt in the same cycle (key_data=105, eth_data=0x0A0B0C), each acked immediately:
  - First pulse is irq_eth with irq_data=0x000A0B0C.
  - Then irq_key with 105.
  - Pulses are at least 3 cycles apart.
- 6 key_evts (codes 101..106) while the first interrupt is unacked, KEY_DEPTH=4:
  - key_drops=1.
  - Subsequent acks deliver 101,102,103,104,105 in order.
- No ack, ACK_TIMEOUT=16:
  - Pulse at t+2, timeouts=1 after 16 cycles.
  - The next queued event is delivered.
- Push into a full ETH FIFO in the same cycle IDLE pops it: frame accepted, eth_drops unchanged.
- rst_n low for 1 cycle while in WAIT_ACK with 3 queued events: all outputs 0, no further pulses without new events.
